reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//  32-entry integer register file directly upstream of the ALU: RD1 drives ALUop1, RD2 drives the
//  ALUop2 source mux. One synchronous write port (writeback), two combinational read ports,
//  optional write-to-read bypass, plus a dedicated a0 (x10) output for the testbench/display.
//  x0 is hardwired to zero. Write-enable and data come from the writeback stage of the same core.
// PARAMETERS
//  DATA_WIDTH     32  width of every register and data port
//  ADDR_WIDTH     5   register index width (2**ADDR_WIDTH entries)
//  BYPASS_EN      1   1: read of the register being written this cycle returns WD3 (write-through)
//  A0_INDEX       10  register index mirrored on a0
// PORTS
//  clk    in   1           rising-edge clock
//  rst    in   1           asynchronous, active-high reset
//  AD1    in   ADDR_WIDTH  read address, port 1 (rs1)
//  AD2    in   ADDR_WIDTH  read address, port 2 (rs2)
//  AD3    in   ADDR_WIDTH  write address (rd)
//  WE3    in   1           write enable, sampled on rising clk
//  WD3    in   DATA_WIDTH  write data
//  RD1    out  DATA_WIDTH  read data, port 1 (to ALUop1)
//  RD2    out  DATA_WIDTH  read data, port 2 (to ALUop2 mux)
//  a0     out  DATA_WIDTH  registered copy of reg[A0_INDEX]
// BEHAVIOUR
//  - Clocking: one clock domain (clk); rst is asynchronous, active-high.
//  - Reset: while rst=1, every register is cleared to 0 immediately (not on a clk edge).
//    a0=0, and RD1/RD2 read 0 for every address. A write presented while rst=1 is discarded.
//  - Release of rst: the first rising clk edge with rst=0 may perform a write.
//  - Write: on rising clk, if WE3=1 and AD3!=0, reg[AD3] <= WD3. Otherwise no state change.
//  - x0: any write to AD3=0 is ignored. Reads of address 0 return 0 on both ports,
//    including when bypass is active.
//  - Read: RD1=reg[AD1] and RD2=reg[AD2], combinational, zero-cycle latency.
//    AD1==AD2 is legal and both ports return the same value.
//  - Bypass (BYPASS_EN=1): if WE3=1, AD3!=0 and ADx==AD3, then RDx=WD3 in the same cycle.
//    Port 1 and port 2 are evaluated independently, so both may bypass at once.
//    BYPASS_EN=0: RDx shows the old value until the edge, then the new value.
//  - a0: updates on the same edge as the write. A write to A0_INDEX makes a0=WD3 one cycle later.
//    a0 is never bypassed: it always equals reg[A0_INDEX] after the edge.
//  - Widths: no sign/zero extension inside the block. Addresses use all ADDR_WIDTH bits;
//    no out-of-range entries exist.
//  - Simultaneous rst and WE3: rst wins, and the register stays 0.
//  - No X on outputs after reset for any input combination.
// STRUCTURE
//  - riscv_pkg (shared): DATA_WIDTH, ADDR_WIDTH constants; typedef word_t
//    (logic [DATA_WIDTH-1:0]); typedef reg_addr_t (logic [ADDR_WIDTH-1:0]);
//    localparam REG_ZERO=0, REG_A0=10.
//  - Storage: array of word_t, 2**ADDR_WIDTH deep, in a single always_ff with async rst.
//  - Sub-module: reg_read_port, instantiated twice (AD1/RD1, AD2/RD2).
//    It implements the x0-zero and bypass mux, so the two read paths stay identical.
//  - a0 is driven from the storage array; there is no separate flop.
// TESTING
//  1. Reset: assert rst mid-run after writing x5=32'hDEAD_BEEF
//     -> RD1(AD1=5)=0 immediately; a0=0; no clk edge needed.
//  2. Write/read: WE3=1, AD3=7, WD3=32'h0000_1234, one edge, then AD1=7, AD2=7
//     -> RD1=RD2=32'h0000_1234.
//  3. x0: WE3=1, AD3=0, WD3=32'hFFFF_FFFF -> RD1(AD1=0)=0 before and after the edge,
//     with BYPASS_EN=1 and =0.
//  4. Bypass: x3=5 stored; WE3=1, AD3=3, WD3=9, AD1=3, AD2=4, same cycle
//     -> RD1=9 (BYPASS_EN=1) or 5 (BYPASS_EN=0); RD2=reg[4] unchanged.
//  5. a0: WE3=1, AD3=10, WD3=32'h0000_00FF
//     -> a0 stays old value until the edge, =32'h0000_00FF after; WE3=0 holds it.
//  6. rst vs write: rst=1 with WE3=1, AD3=2, WD3=1 across an edge
//     -> reg[2]=0 after rst releases; the first post-reset write lands normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core-wide types and constants for the integer datapath.
package riscv_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_A0   = 10;

endpackage

// File: rtl/reg_read_port.sv
// One combinational read path: stored value, optional write-through bypass, x0 forced to zero.
module reg_read_port #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          BYPASS_EN  = 1'b1
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] stored,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] data
);
  import riscv_pkg::*;

  logic is_zero;
  logic hit;

  assign is_zero = (addr == ADDR_WIDTH'(REG_ZERO));
  assign hit     = BYPASS_EN && wr_en && (wr_addr == addr);

  // x0 check comes last so it overrides a bypass hit.
  always_comb begin
    data = stored;
    if (hit) begin
      data = wr_data;
    end
    if (is_zero) begin
      data = '0;
    end
  end

endmodule

// File: rtl/reg_file.sv
// 32-entry integer register file: one write port, two bypassable read ports, a0 mirror.
module reg_file #(
  parameter int unsigned DATA_WIDTH = riscv_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = riscv_pkg::ADDR_WIDTH,
  parameter bit          BYPASS_EN  = 1'b1,
  parameter int unsigned A0_INDEX   = riscv_pkg::REG_A0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] AD1,
  input  logic [ADDR_WIDTH-1:0] AD2,
  input  logic [ADDR_WIDTH-1:0] AD3,
  input  logic                  WE3,
  input  logic [DATA_WIDTH-1:0] WD3,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  output logic [DATA_WIDTH-1:0] a0
);
  import riscv_pkg::*;

  localparam int unsigned            Depth   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0]  A0_ADDR = ADDR_WIDTH'(A0_INDEX);

  logic [DATA_WIDTH-1:0] regs_q [Depth];
  logic                  wr_fire;
  logic                  byp_en;

  assign wr_fire = WE3 && (AD3 != ADDR_WIDTH'(REG_ZERO));
  // Reset also suppresses bypass so reads stay zero while rst is held.
  assign byp_en  = wr_fire && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_fire) begin
      regs_q[AD3] <= WD3;
    end
  end

  reg_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS_EN  (BYPASS_EN)
  ) u_rd1 (
    .addr    (AD1),
    .stored  (regs_q[AD1]),
    .wr_en   (byp_en),
    .wr_addr (AD3),
    .wr_data (WD3),
    .data    (RD1)
  );

  reg_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS_EN  (BYPASS_EN)
  ) u_rd2 (
    .addr    (AD2),
    .stored  (regs_q[AD2]),
    .wr_en   (byp_en),
    .wr_addr (AD3),
    .wr_data (WD3),
    .data    (RD2)
  );

  // Never bypassed: a0 reflects the stored register only.
  assign a0 = regs_q[A0_ADDR];

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: one bypassing and one non-bypassing instance on shared inputs.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  AD1, AD2, AD3;
  logic        WE3;
  logic [31:0] WD3;
  logic [31:0] rd1_b, rd2_b, a0_b;
  logic [31:0] rd1_n, rd2_n, a0_n;

  reg_file #(.BYPASS_EN(1'b1)) dut_byp (
    .clk (clk), .rst (rst), .AD1 (AD1), .AD2 (AD2), .AD3 (AD3),
    .WE3 (WE3), .WD3 (WD3), .RD1 (rd1_b), .RD2 (rd2_b), .a0 (a0_b)
  );

  reg_file #(.BYPASS_EN(1'b0)) dut_nob (
    .clk (clk), .rst (rst), .AD1 (AD1), .AD2 (AD2), .AD3 (AD3),
    .WE3 (WE3), .WD3 (WD3), .RD1 (rd1_n), .RD2 (rd2_n), .a0 (a0_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {SRd1B, SRd2B, SA0B, SRd1N, SRd2N, SA0N} sig_e;
  typedef struct {
    string       name;
    sig_e        sig;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  event sample_ev;
  int   n_checks = 0;
  int   n_fails  = 0;
  bit   done     = 1'b0;

  // Monitor: drains every expectation queued for the current sample point.
  initial begin
    forever begin
      @(sample_ev);
      while (q.size() > 0) begin
        exp_t        e;
        logic [31:0] act;
        e = q.pop_front();
        case (e.sig)
          SRd1B:   act = rd1_b;
          SRd2B:   act = rd2_b;
          SA0B:    act = a0_b;
          SRd1N:   act = rd1_n;
          SRd2N:   act = rd2_n;
          default: act = a0_n;
        endcase
        n_checks++;
        if (act !== e.exp) begin
          n_fails++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  // Watchdog: the stimulus must finish well within this bound.
  initial begin
    #100000;
    if (!done) begin
      n_fails++;
      $display("FAIL timeout: test did not complete in time");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
    end
  end

  task automatic check_now(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_val(input string name, input sig_e sig, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.exp  = exp;
    q.push_back(e);
  endtask

  // Same expectation on both instances.
  task automatic expect_both(input string name, input int port, input logic [31:0] exp);
    if (port == 1) begin
      expect_val({name, "_rd1_byp"}, SRd1B, exp);
      expect_val({name, "_rd1_nob"}, SRd1N, exp);
    end else if (port == 2) begin
      expect_val({name, "_rd2_byp"}, SRd2B, exp);
      expect_val({name, "_rd2_nob"}, SRd2N, exp);
    end else begin
      expect_val({name, "_a0_byp"}, SA0B, exp);
      expect_val({name, "_a0_nob"}, SA0N, exp);
    end
  endtask

  task automatic sample();
    #1;
    -> sample_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write(input logic [4:0] addr, input logic [31:0] data);
    WE3 = 1'b1; AD3 = addr; WD3 = data;
    tick();
    WE3 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; WE3 = 1'b0; AD1 = 5'd5; AD2 = 5'd10; AD3 = '0; WD3 = '0;
    @(negedge clk);
    expect_both("init_reset", 1, 32'h0);
    expect_both("init_reset", 3, 32'h0);
    sample();
    check_now("init_reset_direct_rd2_byp", rd2_b, 32'h0);
    check_now("init_reset_direct_a0_nob", a0_n, 32'h0);

    // 1. async reset mid-run clears a previously written register
    rst = 1'b0;
    tick();
    write(5'd5, 32'hDEAD_BEEF);
    AD1 = 5'd5;
    expect_both("x5_written", 1, 32'hDEAD_BEEF);
    sample();
    rst = 1'b1;
    expect_both("async_rst_x5", 1, 32'h0);
    expect_both("async_rst", 3, 32'h0);
    sample();
    check_now("async_rst_direct_rd1_byp", rd1_b, 32'h0);
    rst = 1'b0;
    tick();

    // 2. write then read on both ports with AD1==AD2
    write(5'd7, 32'h0000_1234);
    AD1 = 5'd7; AD2 = 5'd7;
    expect_both("wr_rd_x7", 1, 32'h0000_1234);
    expect_both("wr_rd_x7", 2, 32'h0000_1234);
    sample();

    // 3. x0 ignores writes and never bypasses
    WE3 = 1'b1; AD3 = 5'd0; WD3 = 32'hFFFF_FFFF; AD1 = 5'd0; AD2 = 5'd0;
    expect_both("x0_pre_edge", 1, 32'h0);
    expect_both("x0_pre_edge", 2, 32'h0);
    sample();
    tick();
    WE3 = 1'b0;
    expect_both("x0_post_edge", 1, 32'h0);
    expect_both("x0_post_edge", 2, 32'h0);
    sample();

    // 4. bypass on port 1 only; port 2 reads an untouched register
    write(5'd4, 32'h0000_0044);
    write(5'd3, 32'd5);
    WE3 = 1'b1; AD3 = 5'd3; WD3 = 32'd9; AD1 = 5'd3; AD2 = 5'd4;
    expect_val("bypass_rd1_byp", SRd1B, 32'd9);
    expect_val("bypass_rd1_nob", SRd1N, 32'd5);
    expect_both("bypass_other", 2, 32'h0000_0044);
    sample();
    tick();
    WE3 = 1'b0;
    expect_both("bypass_after_edge", 1, 32'd9);
    sample();

    // both ports bypass at once
    WE3 = 1'b1; AD3 = 5'd6; WD3 = 32'h66; AD1 = 5'd6; AD2 = 5'd6;
    expect_val("dual_byp_rd1", SRd1B, 32'h66);
    expect_val("dual_byp_rd2", SRd2B, 32'h66);
    expect_val("dual_nob_rd1", SRd1N, 32'h0);
    expect_val("dual_nob_rd2", SRd2N, 32'h0);
    sample();
    tick();
    WE3 = 1'b0;

    // 5. a0 updates only at the edge, and holds afterwards
    WE3 = 1'b1; AD3 = 5'd10; WD3 = 32'h0000_00FF; AD1 = 5'd10;
    expect_both("a0_pre_edge", 3, 32'h0);
    expect_val("a0_rd1_bypass", SRd1B, 32'h0000_00FF);
    sample();
    tick();
    WE3 = 1'b0;
    expect_both("a0_post_edge", 3, 32'h0000_00FF);
    sample();
    tick();
    expect_both("a0_hold", 3, 32'h0000_00FF);
    sample();

    // 6. reset beats a simultaneous write, including across a clock edge
    rst = 1'b1; WE3 = 1'b1; AD3 = 5'd2; WD3 = 32'd1; AD1 = 5'd2; AD2 = 5'd7;
    expect_both("rst_no_bypass", 1, 32'h0);
    sample();
    tick();
    rst = 1'b0; WE3 = 1'b0;
    expect_both("rst_wins_x2", 1, 32'h0);
    expect_both("rst_cleared_x7", 2, 32'h0);
    expect_both("rst_cleared_a0", 3, 32'h0);
    sample();
    check_now("rst_wins_direct_rd1_nob", rd1_n, 32'h0);
    write(5'd2, 32'd1);
    expect_both("post_rst_write", 1, 32'd1);
    sample();

    #2;
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
